// File: rtl/id_ex_reg_pkg.sv
// Control-word layout and destination-register encodings shared by the decode/execute boundary.
package id_ex_reg_pkg;

    localparam int CTRL_LEN       = 31;
    localparam int CTRL_MEMWRITE  = 30;
    localparam int CTRL_REGWRITE  = 29;
    localparam int CTRL_EXTOP     = 25;
    localparam int CTRL_REGDST_HI = 22;
    localparam int CTRL_REGDST_LO = 21;
    localparam int CTRL_TNEW_HI   = 10;
    localparam int CTRL_TNEW_LO   = 8;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [4:0] REG_RA = 5'd31;

    // Encoding 3 is unused by decode and resolves to $0, which disables the write.
    function automatic logic [4:0] sel_waddr(input logic [1:0] regdst, input logic [31:0] ins);
        logic [4:0] waddr;
        case (regdst)
            REGDST_RT: waddr = ins[20:16];
            REGDST_RD: waddr = ins[15:11];
            REGDST_RA: waddr = REG_RA;
            default:   waddr = 5'd0;
        endcase
        return waddr;
    endfunction

endpackage

// File: rtl/id_ex_reg_ext_unit.sv
// 16->32 immediate extender, sign or zero according to sign_ext.
// Latency: combinational. Backpressure: none.
// Shared by any stage that needs an extended immediate.
module ext_unit (
    input  logic [15:0] imm,
    input  logic        sign_ext,
    output logic [31:0] ext
);

    assign ext = {{16{sign_ext & imm[15]}}, imm};

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded instruction, PC, control and operands into E.
// Latency: one cycle, outputs driven only from stored state.
// Backpressure: none; E is loaded every cycle, Stall/Flush load a nop bubble.
module id_ex_reg #(
    parameter int          CTRL_LEN = id_ex_reg_pkg::CTRL_LEN,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Stall,
    input  logic                Flush,
    input  logic [31:0]         InsIn,
    input  logic [31:0]         PCIn,
    input  logic [CTRL_LEN-1:0] CtrlIn,
    input  logic [31:0]         RsDataIn,
    input  logic [31:0]         RtDataIn,
    output logic [31:0]         InsOut,
    output logic [31:0]         PCOut,
    output logic [CTRL_LEN-1:0] CtrlOut,
    output logic [31:0]         RsDataOut,
    output logic [31:0]         RtDataOut,
    output logic [31:0]         ExtOut,
    output logic [4:0]          WriteAddrOut
);

    import id_ex_reg_pkg::*;

    logic [31:0]         ins_q;
    logic [31:0]         pc_q;
    logic [CTRL_LEN-1:0] ctrl_q;
    logic [31:0]         rs_q;
    logic [31:0]         rt_q;
    logic [31:0]         ext_q;
    logic [4:0]          waddr_q;

    logic [31:0]         ext_d;
    logic [4:0]          waddr_d;
    logic                bubble;

    assign bubble  = Stall | Flush;
    assign waddr_d = sel_waddr(CtrlIn[CTRL_REGDST_HI:CTRL_REGDST_LO], InsIn);

    ext_unit u_ext (
        .imm      (InsIn[15:0]),
        .sign_ext (CtrlIn[CTRL_EXTOP]),
        .ext      (ext_d)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ins_q   <= '0;
            pc_q    <= RESET_PC;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            ext_q   <= '0;
            waddr_q <= '0;
        end else if (bubble) begin
            // PC still advances so a debug trace shows where the bubble came from.
            ins_q   <= '0;
            pc_q    <= PCIn;
            ctrl_q  <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            ext_q   <= '0;
            waddr_q <= '0;
        end else begin
            ins_q   <= InsIn;
            pc_q    <= PCIn;
            ctrl_q  <= CtrlIn;
            rs_q    <= RsDataIn;
            rt_q    <= RtDataIn;
            ext_q   <= ext_d;
            waddr_q <= waddr_d;
        end
    end

    logic [2:0] tnew_q;
    logic [2:0] tnew_dec;

    assign tnew_q   = ctrl_q[CTRL_TNEW_HI:CTRL_TNEW_LO];
    assign tnew_dec = (tnew_q == 3'd0) ? 3'd0 : tnew_q - 3'd1;

    // RegWrite is masked for $0 so the forwarding network never matches it.
    always_comb begin
        CtrlOut                              = ctrl_q;
        CtrlOut[CTRL_TNEW_HI:CTRL_TNEW_LO]   = tnew_dec;
        CtrlOut[CTRL_REGWRITE]               = ctrl_q[CTRL_REGWRITE] & (waddr_q != 5'd0);
    end

    assign InsOut       = ins_q;
    assign PCOut        = pc_q;
    assign RsDataOut    = rs_q;
    assign RtDataOut    = rt_q;
    assign ExtOut       = ext_q;
    assign WriteAddrOut = waddr_q;

endmodule
